// File: rtl/lightcube_pkg.sv
// Shared light-cube definitions: frame geometry, mode encodings and frame-source states.
package lightcube_pkg;

   localparam int unsigned N_LAYERS   = 8;
   localparam int unsigned LAYER_BITS = 64;
   localparam int unsigned FRAME_W    = N_LAYERS * LAYER_BITS;

   localparam logic [1:0] MODE_DFLT = 2'b00;
   localparam logic [1:0] MODE_UART = 2'b01;
   localparam logic [1:0] MODE_AUTO = 2'b10;

   typedef enum logic {
      SRC_DFLT = 1'b0,
      SRC_UART = 1'b1
   } src_e;

endpackage

// File: rtl/src_timeout_timer.sv
// UART-silence timer: counts while run_i, reload_i restarts from zero, expire_o pulses
// combinationally in the cycle the count sits at TIMEOUT_CYC-1 (a reload that cycle wins).
module src_timeout_timer #(
   parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
   input  logic clk,
   input  logic resetn,
   input  logic run_i,
   input  logic reload_i,
   output logic expire_o
);

   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      expire_o = run_i && !reload_i && (cnt_q == TERM);
      cnt_d    = cnt_q;
      if (!run_i || reload_i || expire_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/frame_source_arbiter.sv
// Selects UART or default-animation frames and commits them only at full-cube scan boundaries.
// Define FRAME_DROP_CNT_EN to add the saturating drop_cnt output for overwritten pending frames.
module frame_source_arbiter
   import lightcube_pkg::*;
#(
   parameter int unsigned FRAME_W     = lightcube_pkg::FRAME_W,
   parameter int unsigned TIMEOUT_CYC = 100_000_000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [1:0]         mode,
   input  logic [FRAME_W-1:0] uart_frame,
   input  logic               uart_valid,
   input  logic [FRAME_W-1:0] dflt_frame,
   input  logic               dflt_valid,
   input  logic               scan_done,
   output logic               dflt_enable,
   output logic               active_src,
   output logic [FRAME_W-1:0] frame_cube_flat,
   output logic [CNT_W-1:0]   frame_cnt
`ifdef FRAME_DROP_CNT_EN
   ,
   output logic [15:0]        drop_cnt
`endif
);

   src_e               state_q, state_d;
   logic [FRAME_W-1:0] pend_frame_q, pend_frame_d;
   logic               pend_vld_q, pend_vld_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               auto_mode, expire, acc_uart, acc_dflt, accept, commit;

   assign auto_mode = (mode & MODE_AUTO) != '0;

   src_timeout_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk      (clk),
      .resetn   (resetn),
      .run_i    (auto_mode && (state_q == SRC_UART)),
      .reload_i (uart_valid),
      .expire_o (expire)
   );

   always_comb begin
      state_d = state_q;
      case (mode)
         MODE_DFLT: state_d = SRC_DFLT;
         MODE_UART: state_d = SRC_UART;
         default: begin
            if (state_q == SRC_DFLT) begin
               state_d = uart_valid ? SRC_UART : SRC_DFLT;
            end else begin
               state_d = expire ? SRC_DFLT : SRC_UART;
            end
         end
      endcase
   end

   // Auto-mode UART takeover captures its frame in the same cycle it wins the source.
   always_comb begin
      acc_uart     = uart_valid && ((state_q == SRC_UART) || auto_mode);
      acc_dflt     = dflt_valid && (state_q == SRC_DFLT) && !acc_uart;
      accept       = acc_uart || acc_dflt;
      commit       = scan_done && pend_vld_q;
      pend_frame_d = pend_frame_q;
      if (accept) begin
         pend_frame_d = acc_uart ? uart_frame : dflt_frame;
      end
      pend_vld_d = accept || (pend_vld_q && !commit);
      frame_d    = commit ? pend_frame_q : frame_q;
      cnt_d      = commit ? (cnt_q + CNT_W'(1)) : cnt_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= SRC_DFLT;
         pend_frame_q <= '0;
         pend_vld_q   <= 1'b0;
         frame_q      <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pend_frame_q <= pend_frame_d;
         pend_vld_q   <= pend_vld_d;
         frame_q      <= frame_d;
         cnt_q        <= cnt_d;
      end
   end

   assign active_src      = (state_q == SRC_UART);
   assign dflt_enable     = (state_q == SRC_DFLT);
   assign frame_cube_flat = frame_q;
   assign frame_cnt       = cnt_q;

`ifdef FRAME_DROP_CNT_EN
   logic [15:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (accept && pend_vld_q && !commit && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_frame_source_arbiter.sv
// Directed self-checking bench for frame_source_arbiter (TIMEOUT_CYC=100, plus a CNT_W=2 copy for wrap).
module tb_frame_source_arbiter;

   localparam int unsigned FW = 512;

   logic          clk = 1'b0;
   logic          resetn;
   logic [1:0]    mode;
   logic [FW-1:0] uart_frame, dflt_frame;
   logic          uart_valid, dflt_valid, scan_done;

   logic          dflt_enable, active_src;
   logic [FW-1:0] frame_cube_flat;
   logic [31:0]   frame_cnt;
   logic          w_dflt_enable, w_active_src;
   logic [FW-1:0] w_frame_cube_flat;
   logic [1:0]    w_frame_cnt;
`ifdef FRAME_DROP_CNT_EN
   logic [15:0]   drop_cnt, w_drop_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   frame_source_arbiter #(.FRAME_W(FW), .TIMEOUT_CYC(100), .CNT_W(32)) dut (
      .clk(clk), .resetn(resetn), .mode(mode),
      .uart_frame(uart_frame), .uart_valid(uart_valid),
      .dflt_frame(dflt_frame), .dflt_valid(dflt_valid), .scan_done(scan_done),
      .dflt_enable(dflt_enable), .active_src(active_src),
      .frame_cube_flat(frame_cube_flat), .frame_cnt(frame_cnt)
`ifdef FRAME_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   frame_source_arbiter #(.FRAME_W(FW), .TIMEOUT_CYC(100), .CNT_W(2)) dut_w (
      .clk(clk), .resetn(resetn), .mode(mode),
      .uart_frame(uart_frame), .uart_valid(uart_valid),
      .dflt_frame(dflt_frame), .dflt_valid(dflt_valid), .scan_done(scan_done),
      .dflt_enable(w_dflt_enable), .active_src(w_active_src),
      .frame_cube_flat(w_frame_cube_flat), .frame_cnt(w_frame_cnt)
`ifdef FRAME_DROP_CNT_EN
      , .drop_cnt(w_drop_cnt)
`endif
   );

   task automatic check_eq(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic uv, input logic dv, input logic sd);
      uart_valid = uv;
      dflt_valid = dv;
      scan_done  = sd;
      tick();
      uart_valid = 1'b0;
      dflt_valid = 1'b0;
      scan_done  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic check_frame(input string tag, input logic [FW-1:0] f, input logic [31:0] c);
      check_eq({tag, "_frame"}, frame_cube_flat, f);
      check_eq({tag, "_cnt"}, FW'(frame_cnt), FW'(c));
   endtask

   initial begin
      resetn = 1'b0; mode = 2'b00;
      uart_frame = '0; dflt_frame = '0;
      uart_valid = 1'b0; dflt_valid = 1'b0; scan_done = 1'b0;
      idle(2);
      resetn = 1'b1;
      tick();

      check_frame("rst", '0, 0);
      check_eq("rst_active", FW'(active_src), FW'(0));
      check_eq("rst_dflt_en", FW'(dflt_enable), FW'(1));
`ifdef FRAME_DROP_CNT_EN
      check_eq("rst_drop", FW'(drop_cnt), FW'(0));
`endif

      // Mode 00: UART ignored, default frame commits at scan boundary
      uart_frame = 512'hBAD;
      cyc(1, 0, 0);
      cyc(0, 0, 1);
      check_frame("m0_uart_ign", '0, 0);
      check_eq("m0_active", FW'(active_src), FW'(0));
      dflt_frame = 512'h1;
      cyc(0, 1, 0);
      idle(9);
      check_frame("m0_hold", '0, 0);
      cyc(0, 0, 1);
      check_frame("m0_commit", 512'h1, 1);
      uart_frame = 512'h6;
      cyc(1, 0, 0);
      cyc(0, 0, 1);
      check_frame("m0_uart_ign2", 512'h1, 1);

      // Overwrite: latest pending wins, one commit
      dflt_frame = 512'hC; cyc(0, 1, 0);
      dflt_frame = 512'hD; cyc(0, 1, 0);
      cyc(0, 0, 1);
      check_frame("ovw", 512'hD, 2);
`ifdef FRAME_DROP_CNT_EN
      check_eq("ovw_drop", FW'(drop_cnt), FW'(1));
`endif

      // Coincident valid + scan_done with nothing pending
      dflt_frame = 512'hE; cyc(0, 1, 1);
      check_frame("coin_nocommit", 512'hD, 2);
      cyc(0, 0, 1);
      check_frame("coin_commit", 512'hE, 3);
      dflt_frame = 512'h8; cyc(0, 1, 0);
      dflt_frame = 512'h9; cyc(0, 1, 1);
      check_frame("coin_old", 512'h8, 4);
`ifdef FRAME_DROP_CNT_EN
      check_eq("coin_nodrop", FW'(drop_cnt), FW'(1));
`endif
      cyc(0, 0, 1);
      check_frame("coin_new", 512'h9, 5);

      // Auto mode: UART takeover and timeout fallback
      mode = 2'b10;
      tick();
      check_eq("auto_pre", FW'(active_src), FW'(0));
      uart_frame = 512'hB0B;
      cyc(1, 0, 0);
      check_eq("auto_take_act", FW'(active_src), FW'(1));
      check_eq("auto_take_den", FW'(dflt_enable), FW'(0));
      cyc(0, 0, 1);
      check_frame("auto_commit", 512'hB0B, 6);
      dflt_frame = 512'h3; cyc(0, 1, 0);
      idle(97);
      check_eq("to_99", FW'(active_src), FW'(1));
      tick();
      check_eq("to_100", FW'(active_src), FW'(0));
      check_eq("to_100_den", FW'(dflt_enable), FW'(1));
      cyc(0, 0, 1);
      check_frame("auto_dflt_ign", 512'hB0B, 6);

      // UART valid in the expiry cycle keeps UART and reloads the timer
      uart_frame = 512'h4B; cyc(1, 0, 0);
      idle(99);
      uart_frame = 512'h4C; cyc(1, 0, 0);
      check_eq("exp_race", FW'(active_src), FW'(1));
      idle(99);
      check_eq("reload_99", FW'(active_src), FW'(1));
      tick();
      check_eq("reload_100", FW'(active_src), FW'(0));
      cyc(0, 0, 1);
      check_frame("pend_survive", 512'h4C, 7);
`ifdef FRAME_DROP_CNT_EN
      check_eq("race_drop", FW'(drop_cnt), FW'(2));
`endif
      check_eq("w_pre_rst", FW'(w_frame_cnt), FW'(3));

      // Reset mid-operation with a pending frame
      dflt_frame = 512'h77; cyc(0, 1, 0);
      resetn = 1'b0;
      tick();
      check_frame("rst2", '0, 0);
      check_eq("rst2_active", FW'(active_src), FW'(0));
      check_eq("rst2_den", FW'(dflt_enable), FW'(1));
`ifdef FRAME_DROP_CNT_EN
      check_eq("rst2_drop", FW'(drop_cnt), FW'(0));
`endif
      resetn = 1'b1;
      mode = 2'b00;
      tick();
      cyc(0, 0, 1);
      check_frame("rst2_nocommit", '0, 0);

      // Counter wrap on the CNT_W=2 instance
      for (int i = 1; i <= 3; i++) begin
         dflt_frame = FW'(i);
         cyc(0, 1, 0);
         cyc(0, 0, 1);
      end
      check_eq("wrap_3", FW'(w_frame_cnt), FW'(3));
      dflt_frame = 512'h4; cyc(0, 1, 0);
      cyc(0, 0, 1);
      check_eq("wrap_0", FW'(w_frame_cnt), FW'(0));
      check_frame("wrap_main", 512'h4, 4);

      // Mode 01: UART only, timeout ignored
      mode = 2'b01;
      tick();
      check_eq("m1_act", FW'(active_src), FW'(1));
      dflt_frame = 512'h55; cyc(0, 1, 0);
      cyc(0, 0, 1);
      check_frame("m1_dflt_ign", 512'h4, 4);
      uart_frame = 512'hABC; cyc(1, 0, 0);
      idle(150);
      check_eq("m1_no_to", FW'(active_src), FW'(1));
      cyc(0, 0, 1);
      check_frame("m1_commit", 512'hABC, 5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
